// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state and grant encodings shared by the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;
  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } arb_grant_e;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating count of DM grants taken while a fetch was waiting
module arb_starve_ctr #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);
  logic [W-1:0] r_cnt;
  assign o_at_max = (r_cnt >= W'(MAX));
  // clear on a fetch grant, otherwise count bypasses and hold at MAX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !o_at_max) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-at-a-time sharing of a single memory port between fetch and data access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter int FETCH_STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_ack,
  input  logic                i_dm_req,
  input  logic [DATA_W/8-1:0] i_dm_we,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_dm_ack,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W/8-1:0] o_mem_we,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_resp_valid,
  input  logic [DATA_W-1:0]   i_mem_resp_data,
  output logic                o_stall_fd,
  output logic                o_err
);
  localparam int BE_W = DATA_W/8;
  arb_state_e        r_state, w_next;
  arb_grant_e        r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_we;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;
  logic              r_err;
  logic              w_launch, w_grant_dm, w_at_max;
  assign w_launch   = (r_state == ST_IDLE) & (i_if_req | i_dm_req);
  assign w_grant_dm = i_dm_req & ~(i_if_req & w_at_max);
  arb_starve_ctr #(.W(STARVE_W), .MAX(FETCH_STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_launch & w_grant_dm & i_if_req),
    .i_clr    (w_launch & ~w_grant_dm),
    .o_at_max (w_at_max)
  );
  // one transaction walks IDLE -> REQ -> WAIT -> RESP; only IDLE looks at requests
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ST_IDLE) ? ((i_if_req | i_dm_req) ? ST_REQ  : ST_IDLE) :
             (r_state == ST_REQ)  ? (i_mem_req_ready       ? ST_WAIT : ST_REQ)  :
             (r_state == ST_WAIT) ? (i_mem_resp_valid      ? ST_RESP : ST_WAIT) : ST_IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // latch the winner's request so later requester changes cannot disturb the memory side
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_grant <= GRANT_IF;
      r_addr  <= '0;
      r_we    <= '0;
      r_wdata <= '0;
    end else if (w_launch) begin
      r_grant <= w_grant_dm ? GRANT_DM : GRANT_IF;
      r_addr  <= w_grant_dm ? i_dm_addr : i_if_addr;
      r_we    <= w_grant_dm ? i_dm_we : '0;
      r_wdata <= w_grant_dm ? i_dm_wdata : '0;
    end
  // route the memory response to the granted requester's data register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (r_state == ST_WAIT && i_mem_resp_valid) begin
      if (r_grant == GRANT_DM) r_dm_rdata <= i_mem_resp_data;
      else r_if_rdata <= i_mem_resp_data;
    end
  // a response arriving outside WAIT is a memory-side protocol error, kept until reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else if (i_mem_resp_valid && r_state != ST_WAIT) r_err <= 1'b1;
  assign o_mem_req_valid = (r_state == ST_REQ);
  assign o_mem_addr      = r_addr;
  assign o_mem_we        = r_we;
  assign o_mem_wdata     = r_wdata;
  assign o_if_rdata      = r_if_rdata;
  assign o_dm_rdata      = r_dm_rdata;
  assign o_if_ack        = (r_state == ST_RESP) & (r_grant == GRANT_IF);
  assign o_dm_ack        = (r_state == ST_RESP) & (r_grant == GRANT_DM);
  assign o_err           = r_err;
  assign o_stall_fd      = rst_n & ((i_if_req & ~o_if_ack) | (i_dm_req & ~o_dm_ack));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of the arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = DW/8, SMAX = 4;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, dm_req = 0, mem_req_ready = 0, mem_resp_valid = 0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [BW-1:0] dm_we = '0;
  logic [DW-1:0] dm_wdata = '0, mem_resp_data = '0;
  logic [DW-1:0] o_if_rdata, o_dm_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [BW-1:0] o_mem_we;
  logic o_if_ack, o_dm_ack, o_mem_req_valid, o_stall_fd, o_err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FETCH_STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_rdata(o_dm_rdata), .o_dm_ack(o_dm_ack),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(mem_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_resp_valid(mem_resp_valid), .i_mem_resp_data(mem_resp_data),
    .o_stall_fd(o_stall_fd), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  logic [DW-1:0] mem [256];
  int starve, delay, n_acks;
  bit in_txn, req_wait, pend, ack_due, cur_dm, err_exp, hold_resp, stray;
  logic [AW-1:0] cur_addr;
  logic [BW-1:0] cur_we;
  logic [DW-1:0] cur_wdata, resp_dat, exp_if_rdata, exp_dm_rdata;
  int if_mode = 0, dm_mode = 0;
  int rdy_pct = 100, max_delay = 0, hold_ready = 0;
  int ack_log[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic new_if();
    if_req = 1;
    if_addr = AW'($urandom_range(0, 255)) << 2;
  endtask

  task automatic new_dm();
    dm_req = 1;
    dm_addr = AW'($urandom_range(0, 255)) << 2;
    dm_we = $urandom_range(0, 1) ? BW'($urandom_range(1, 15)) : '0;
    dm_wdata = $urandom;
  endtask

  task automatic model_clear();
    starve = 0; in_txn = 0; req_wait = 0; pend = 0; ack_due = 0;
    exp_if_rdata = '0; exp_dm_rdata = '0; err_exp = 0;
    hold_ready = 0; hold_resp = 0; stray = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_mem_req_valid, 0);
    chk({tag, "_if_ack"}, o_if_ack, 0);
    chk({tag, "_dm_ack"}, o_dm_ack, 0);
    chk({tag, "_addr"}, o_mem_addr, 0);
    chk({tag, "_we"}, o_mem_we, 0);
    chk({tag, "_wdata"}, o_mem_wdata, 0);
    chk({tag, "_if_rdata"}, o_if_rdata, 0);
    chk({tag, "_dm_rdata"}, o_dm_rdata, 0);
    chk({tag, "_stall"}, o_stall_fd, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; if_req = 0; dm_req = 0; mem_req_ready = 0; mem_resp_valid = 0;
    model_clear();
    #1 chk_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // one clock: observe at the falling edge, then drive the memory side and requesters
  task automatic cycle();
    bit eia, eda, g;
    @(negedge clk);
    eia = ack_due && !cur_dm;
    eda = ack_due && cur_dm;
    chk("if_ack", o_if_ack, eia);
    chk("dm_ack", o_dm_ack, eda);
    if (eia) exp_if_rdata = resp_dat;
    if (eda) exp_dm_rdata = resp_dat;
    chk("if_rdata", o_if_rdata, exp_if_rdata);
    chk("dm_rdata", o_dm_rdata, exp_dm_rdata);
    chk("stall_fd", o_stall_fd, (if_req && !eia) || (dm_req && !eda));
    chk("err", o_err, err_exp);
    if (o_if_ack) ack_log.push_back(0);
    if (o_dm_ack) ack_log.push_back(1);
    if (ack_due) begin in_txn = 0; n_acks++; end
    ack_due = 0;
    if (o_mem_req_valid && !req_wait) begin
      g = dm_req && !(if_req && starve >= SMAX);
      chk("start_idle", in_txn, 0);
      chk("start_req", if_req || dm_req, 1);
      cur_dm = g;
      cur_addr = g ? dm_addr : if_addr;
      cur_we = g ? dm_we : '0;
      cur_wdata = dm_wdata;
      starve = g ? ((if_req && starve < SMAX) ? starve + 1 : starve) : 0;
      in_txn = 1; req_wait = 1;
    end else if (req_wait) chk("valid_hold", o_mem_req_valid, 1);
    if (req_wait) begin
      chk("mem_addr", o_mem_addr, cur_addr);
      chk("mem_we", o_mem_we, cur_we);
      if (cur_dm) chk("mem_wdata", o_mem_wdata, cur_wdata);
    end
    mem_resp_valid = 0;
    mem_resp_data = $urandom;
    if (pend && !hold_resp) begin
      if (delay == 0) begin
        resp_dat = mem[widx(cur_addr)];
        mem_resp_valid = 1; mem_resp_data = resp_dat; pend = 0; ack_due = 1;
      end else delay--;
    end
    if (stray) begin mem_resp_valid = 1; err_exp = 1; stray = 0; end
    if (req_wait) begin
      if (hold_ready > 0) begin mem_req_ready = 0; hold_ready--; end
      else mem_req_ready = ($urandom_range(0, 99) < rdy_pct);
      if (mem_req_ready) begin
        req_wait = 0; pend = 1; delay = $urandom_range(0, max_delay);
        if (cur_dm)
          for (int b = 0; b < BW; b++)
            if (cur_we[b]) mem[widx(cur_addr)][8*b +: 8] = cur_wdata[8*b +: 8];
      end
    end else mem_req_ready = 1'($urandom_range(0, 1));
    if (eia) begin
      if (if_mode == 1 || (if_mode == 2 && $urandom_range(0, 1) == 1)) new_if(); else if_req = 0;
    end else if (!if_req && if_mode == 2 && $urandom_range(0, 2) == 0) new_if();
    if (eda) begin
      if (dm_mode == 1 || (dm_mode == 2 && $urandom_range(0, 1) == 1)) new_dm(); else dm_req = 0;
    end else if (!dm_req && dm_mode == 2 && $urandom_range(0, 2) == 0) new_dm();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k, nv;
    bit done;
    logic [AW-1:0] a0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_clear();
    n_acks = 0;
    @(negedge clk);
    chk_zero("por");
    @(negedge clk);
    rst_n = 1;
    // fetch-only load from 0x1000, ack three cycles after the request is seen
    mem[0] = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h1000;
    k = 0;
    do begin cycle(); k++; end while (!o_if_ack && k < 20);
    chk("if_latency", k, 3);
    chk("if_deadbeef", o_if_rdata, 32'hDEADBEEF);
    repeat (2) cycle();
    // reset while the fetch waits for its response
    if_req = 1; if_addr = 32'h40; hold_resp = 1;
    repeat (3) cycle();
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    model_clear();
    if_req = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (8) cycle();
    // simultaneous requests: data first, then fetch
    do_reset();
    ack_log.delete();
    new_if();
    dm_req = 1; dm_we = 4'hF; dm_addr = 32'h2000; dm_wdata = 32'h12345678;
    k = 0;
    while (ack_log.size() < 2 && k < 40) begin cycle(); k++; end
    chk("t3_acks", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      chk("t3_first_dm", ack_log[0], 1);
      chk("t3_second_if", ack_log[1], 0);
    end
    chk("t3_store", mem[widx(32'h2000)], 32'h12345678);
    // starvation bound: four data grants then a forced fetch, twice
    do_reset();
    dm_mode = 1;
    for (int r = 0; r < 2; r++) begin
      ack_log.delete();
      new_if();
      if (r == 0) new_dm();
      k = 0;
      while ((ack_log.size() == 0 || ack_log[$] != 0) && k < 100) begin cycle(); k++; end
      chk("starve_acks", ack_log.size(), 5);
      for (int j = 0; j < 4 && j < ack_log.size(); j++) chk("starve_dm", ack_log[j], 1);
      if (ack_log.size() > 0) chk("starve_if", ack_log[$], 0);
    end
    dm_mode = 0;
    repeat (12) cycle();
    // backpressure: five refused cycles, data inputs wander meanwhile
    do_reset();
    new_dm();
    a0 = dm_addr;
    hold_ready = 5;
    nv = 0; done = 0; k = 0;
    while (!done && k < 30) begin
      cycle();
      if (o_mem_req_valid) begin chk("bp_addr", o_mem_addr, a0); nv++; end
      if (o_dm_ack) done = 1;
      dm_addr = AW'($urandom_range(0, 255)) << 2;
      dm_wdata = $urandom;
      k++;
    end
    chk("bp_done", done, 1);
    chk("bp_valid_cycles", nv, 6);
    // stray response in IDLE raises a sticky error, traffic still completes
    do_reset();
    stray = 1;
    repeat (5) cycle();
    chk("err_sticky", o_err, 1);
    ack_log.delete();
    new_if();
    k = 0;
    while (ack_log.size() == 0 && k < 20) begin cycle(); k++; end
    chk("err_then_if", ack_log.size(), 1);
    chk("err_still", o_err, 1);
    // random traffic with random backpressure and response latency
    do_reset();
    if_mode = 2; dm_mode = 2; rdy_pct = 70; max_delay = 3; n_acks = 0;
    repeat (3000) cycle();
    chk("rand_progress", n_acks > 100, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
